// File: rtl/instr_fetch_if.sv
// Instruction-fetch bundle between the fetch unit, the instruction memory
// and the decode/control path.
//   master : the fetch unit (drives memory request and decoded-side outputs)
//   slave  : the surrounding system (memory response, decode handshake,
//            control-path redirect)
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
    input  imem_ready, imem_rdata, instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
    output imem_ready, imem_rdata, instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at pc, holds it for the decode
// stage until consumed, then fetches pc+4. Taken branches/jumps redirect the
// fetch address; a misaligned redirect target locks the unit in ERR until
// reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - instr_fetch_if.master: imem_req/imem_addr/imem_ready/imem_rdata,
//          instr_valid/instr/instr_pc/instr_ready, redirect/redirect_target,
//          misalign_err
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic        misalign_err_q;

  logic [31:0] pc_d;
  logic        redir_aligned_d;

  // Sequential pc wraps modulo 2^32 by plain 32-bit addition.
  assign pc_d            = pc_q + 32'd4;
  assign redir_aligned_d = (bus.redirect_target[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      instr_q        <= NOP_INSTR;
      instr_pc_q     <= 32'h0;
      imem_req_q     <= 1'b0;
      instr_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
    end else if (state_q != ERR && bus.redirect) begin
      // Redirect outranks both handshakes; any word returned now is dropped.
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      if (redir_aligned_d) begin
        pc_q       <= bus.redirect_target;
        imem_req_q <= 1'b1;
        state_q    <= FETCH;
      end else begin
        misalign_err_q <= 1'b1;
        imem_req_q     <= 1'b0;
        state_q        <= ERR;
      end
    end else begin
      case (state_q)
        FETCH: begin
          // imem_req is low only on the first cycle out of reset; a response
          // is taken only once the request is actually on the bus.
          if (imem_req_q && bus.imem_ready) begin
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_d;
            imem_req_q    <= 1'b0;
            state_q       <= HOLD;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            imem_req_q    <= 1'b1;
            state_q       <= FETCH;
          end
        end
        default: begin
          // ERR is terminal until reset.
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          state_q       <= ERR;
        end
      endcase
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = {pc_q[31:2], 2'b00};
  assign bus.instr_valid  = instr_valid_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory returns address-tagged words
// (rdata = addr ^ 32'hCAFE_0000). Expected {instr_pc, instr} pairs are queued
// as stimulus is issued; a forked monitor pops one per new instr_valid pulse.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if f1 ();
  instr_fetch_if f2 ();

  instr_fetch u_dut (.clk(clk), .rst(rst), .bus(f1));
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (.clk(clk), .rst(rst), .bus(f2));

  assign f1.imem_rdata = f1.imem_addr ^ 32'hCAFE_0000;

  assign f2.imem_rdata      = f2.imem_addr ^ 32'hCAFE_0000;
  assign f2.imem_ready      = 1'b1;
  assign f2.instr_ready     = 1'b1;
  assign f2.redirect        = 1'b0;
  assign f2.redirect_target = 32'h0;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic monitor();
    logic prev_v;
    logic [63:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (f1.instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_instr", {f1.instr_pc, f1.instr}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", {f1.instr_pc, f1.instr}, e);
        end
      end
      prev_v = f1.instr_valid;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int vcnt;
    f1.imem_ready      = 1'b1;
    f1.instr_ready     = 1'b1;
    f1.redirect        = 1'b0;
    f1.redirect_target = 32'h0;
    fork
      monitor();
    join_none

    // Reset state
    tick();
    chk("rst_req", {63'h0, f1.imem_req}, 64'h0);
    chk("rst_valid", {63'h0, f1.instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, f1.instr}, {32'h0, NOP});
    chk("rst_pc_addr", {f1.instr_pc, f1.imem_addr}, 64'h0);
    chk("rst_err", {63'h0, f1.misalign_err}, 64'h0);

    // Streaming: both handshakes always ready
    exp_q.push_back({32'h0000_0000, 32'hCAFE_0000});
    exp_q.push_back({32'h0000_0004, 32'hCAFE_0004});
    exp_q.push_back({32'h0000_0008, 32'hCAFE_0008});
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (f1.instr_valid) vcnt++;
    end
    chk("stream_valid_pulses", 64'(vcnt), 64'd3);
    f1.imem_ready = 1'b0;

    // Memory stall after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req_addr_valid", {31'h0, f1.imem_req, f1.imem_addr, 1'b0, f1.instr_valid},
          {31'h0, 1'b1, 32'h0, 1'b0, 1'b0});
    end
    f1.imem_ready  = 1'b1;
    f1.instr_ready = 1'b0;
    exp_q.push_back({32'h0000_0000, 32'hCAFE_0000});
    tick();
    chk("stall_release_valid", {63'h0, f1.instr_valid}, 64'h1);

    // Decode back-pressure in HOLD
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_instr_pc", {f1.instr_pc, f1.instr}, {32'h0, 32'hCAFE_0000});
      chk("hold_req_valid", {62'h0, f1.imem_req, f1.instr_valid}, 64'h1);
    end
    f1.instr_ready = 1'b1;
    tick();
    chk("hold_next_fetch", {31'h0, f1.imem_req, f1.imem_addr}, {31'h0, 1'b1, 32'h4});
    exp_q.push_back({32'h0000_0004, 32'hCAFE_0004});
    f1.instr_ready = 1'b0;
    tick();

    // Redirect in FETCH together with imem_ready: word at 0x8 dropped
    f1.instr_ready = 1'b1;
    f1.imem_ready  = 1'b0;
    tick();
    chk("redir_pre_addr", {32'h0, f1.imem_addr}, 64'h8);
    f1.redirect        = 1'b1;
    f1.redirect_target = 32'h0000_0100;
    f1.imem_ready      = 1'b1;
    tick();
    f1.redirect    = 1'b0;
    f1.instr_ready = 1'b0;
    chk("redir_fetch_state", {30'h0, f1.imem_req, f1.instr_valid, f1.imem_addr},
        {30'h0, 1'b1, 1'b0, 32'h100});
    exp_q.push_back({32'h0000_0100, 32'hCAFE_0100});
    tick();
    f1.imem_ready = 1'b0;
    chk("redir_result_pc", {31'h0, f1.instr_valid, f1.instr_pc}, {31'h0, 1'b1, 32'h100});

    // Redirect in HOLD
    f1.redirect        = 1'b1;
    f1.redirect_target = 32'h0000_0200;
    tick();
    f1.redirect = 1'b0;
    chk("redir_hold_valid", {63'h0, f1.instr_valid}, 64'h0);
    chk("redir_hold_instr", {32'h0, f1.instr}, {32'h0, NOP});
    chk("redir_hold_addr", {31'h0, f1.imem_req, f1.imem_addr}, {31'h0, 1'b1, 32'h200});

    // Misaligned redirect -> terminal ERR
    f1.redirect        = 1'b1;
    f1.redirect_target = 32'h0000_0102;
    f1.imem_ready      = 1'b1;
    tick();
    chk("err_entry", {61'h0, f1.misalign_err, f1.imem_req, f1.instr_valid}, 64'h4);
    f1.redirect_target = 32'h0000_0300;
    f1.instr_ready     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("err_sticky", {61'h0, f1.misalign_err, f1.imem_req, f1.instr_valid}, 64'h4);
    end
    f1.redirect   = 1'b0;
    f1.imem_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk("err_cleared_by_rst", {62'h0, f1.misalign_err, f1.imem_req}, 64'h0);
    tick();
    rst = 1'b0;

    // Asynchronous reset in HOLD and mid-request
    f1.imem_ready  = 1'b1;
    f1.instr_ready = 1'b0;
    exp_q.push_back({32'h0000_0000, 32'hCAFE_0000});
    tick();
    chk("arst_req_up", {63'h0, f1.imem_req}, 64'h1);
    tick();
    chk("arst_hold_valid", {63'h0, f1.instr_valid}, 64'h1);
    #2 rst = 1'b1;
    #1 chk("arst_hold_drop", {62'h0, f1.imem_req, f1.instr_valid}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_req_addr", {31'h0, f1.imem_req, f1.imem_addr}, {31'h0, 1'b1, 32'h0});
    #2 rst = 1'b1;
    #1 chk("arst_req_drop", {62'h0, f1.imem_req, f1.instr_valid}, 64'h0);
    tick();
    f1.imem_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("arst_word_discarded", {31'h0, f1.instr_valid, f1.instr}, {31'h0, 1'b0, NOP});

    // RESET_PC at top of address space wraps to zero
    do_reset();
    tick();
    chk("wrap_first_addr", {31'h0, f2.imem_req, f2.imem_addr}, {31'h0, 1'b1, 32'hFFFF_FFFC});
    tick();
    chk("wrap_first_instr", {31'h0, f2.instr_valid, f2.instr_pc}, {31'h0, 1'b1, 32'hFFFF_FFFC});
    chk("wrap_first_word", {32'h0, f2.instr}, 64'h3501_FFFC);
    tick();
    tick();
    chk("wrap_second_instr", {31'h0, f2.instr_valid, f2.instr_pc}, {31'h0, 1'b1, 32'h0});
    chk("wrap_second_word", {32'h0, f2.instr}, 64'hCAFE_0000);
    chk("wrap_no_err", {63'h0, f2.misalign_err}, 64'h0);

    tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
